reaction_timer: RTL and testbench
=================================

# reaction_timer

Reaction-time game controller fed directly by the 168-bit Fibonacci LFSR's 4-bit random output `r` (range 2..15). On `start` it samples `r` to pick a random foreperiod, lights the stimulus LED when the foreperiod expires, then measures the player's response in milliseconds. It sits between the LFSR and the display/score logic and flags early presses as cheats.

## Interface
- `TICKS_PER_MS`, default 100000: clock cycles per millisecond tick.
- `DELAY_UNIT_MS`, default 250: milliseconds per unit of `r`.
- `MAX_MS`, default 9999: saturation and timeout value of the reaction count.

Ports:
- `clk`  in  1: single clock.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: single-cycle pulse, debounced upstream; begins a round.
- `stop`  in  1: single-cycle pulse, debounced upstream; the player's response button.
- `r`  in  4: random value from the LFSR.
- `led`  out  1: stimulus; high only in state LIT.
- `busy`  out  1: high in WAIT or LIT.
- `reaction_ms`  out  14: last measured reaction time, held until the next result.
- `valid`  out  1: one-cycle pulse when `reaction_ms` updates.
- `cheat`  out  1: high from an early press until the next `start`.
- `best_ms`  out  14: best (minimum) valid time; see Configuration.

## Operation
- States: IDLE, WAIT, LIT, DONE, FAULT. Reset puts the block in IDLE.
- IDLE/DONE/FAULT + `start`:
  - load `delay_ms = clamp(r,2,15) * DELAY_UNIT_MS`; `r` values 0 and 1 are treated as 2.
  - Clear the prescaler and `cheat`, then go to WAIT.
- Ms tick: the prescaler counts 0..`TICKS_PER_MS`-1 and is cleared on entry to WAIT and to LIT. The tick is asserted when the prescaler equals `TICKS_PER_MS`-1.
- WAIT:
  - Each tick decrements `delay_ms`. The tick that takes it from 1 to 0 moves the block to LIT.
  - `stop` in WAIT sets `cheat`=1 and moves the block to FAULT. `stop` has priority over the expiry tick in the same cycle.
- LIT:
  - `ms_cnt` is cleared on entry and increments on each tick.
  - `stop` latches `reaction_ms = ms_cnt`, pulses `valid`, and moves the block to DONE.
  - If `ms_cnt` reaches `MAX_MS` with no `stop`, latch `reaction_ms = MAX_MS`, pulse `valid`, and move to DONE.
- `start` in WAIT or LIT is ignored. `stop` in IDLE, DONE or FAULT is ignored. If `start` and `stop` arrive together in IDLE, DONE or FAULT, `start` wins.
- Widths:
  - `delay_ms` is 12 bits (maximum 15*250 = 3750).
  - `ms_cnt` and `reaction_ms` are 14 bits.
  - The default `DELAY_UNIT_MS` must keep 15*`DELAY_UNIT_MS` below 4096.
- Reset in any state returns to IDLE immediately. All state is cleared and no `valid` pulse is produced.

## Timing
- Reset values: `led`=0, `busy`=0, `reaction_ms`=0, `valid`=0, `cheat`=0, `best_ms`=`MAX_MS`.
- `start` sampled at edge N: WAIT is entered at N+1, with `busy`=1 from N+1.
- `led` rises exactly `delay_ms`*`TICKS_PER_MS` cycles after WAIT entry.
- `stop` sampled k cycles after LIT entry (k=0 is the first `led`-high cycle) gives `reaction_ms` = floor(k/`TICKS_PER_MS`).
- `reaction_ms` and `valid` are registered and appear on the edge after `stop`. `led` and `busy` fall on that same edge.
- `cheat` rises on the edge after the early `stop`.

## Configuration
- `BEST_TIME_EN` defined:
  - `best_ms` holds the minimum `reaction_ms` over all non-timeout results since reset.
  - It updates in the same cycle as `valid` when the new value is smaller.
  - Timeouts (`MAX_MS`) and cheats never update it.
- `BEST_TIME_EN` undefined: `best_ms` is tied to the constant `MAX_MS` and no comparison register exists.

## Test plan
All scenarios use `TICKS_PER_MS`=4 and `DELAY_UNIT_MS`=2.
- `r`=3, `start`, then `stop` 10 cycles after `led` rises -> `led` rises 24 cycles after WAIT entry; `reaction_ms`=2 with a single `valid` pulse; `busy` falls.
- `r`=5, `stop` 5 cycles into WAIT -> `cheat`=1 and state FAULT with `led` never rising. A later `start` clears `cheat` and begins a new round.
- `r`=0 -> delay identical to `r`=2 (16 cycles). `r`=15 -> 120 cycles.
- No `stop` in LIT -> after 9999*4 cycles `reaction_ms`=9999 with `valid` pulsed; `best_ms` unchanged.
- `reset` asserted mid-LIT -> next cycle `led`=0, `busy`=0, `reaction_ms`=0, no `valid`. Also: `start` and `stop` together in IDLE -> WAIT entered, no cheat.
- With `BEST_TIME_EN`: results 7, 3, 5 -> `best_ms` goes 7, 3, 3. Without `BEST_TIME_EN` -> `best_ms` stays 9999.

Source files
------------

// File: rtl/reaction_timer.sv
// rtl/reaction_timer.sv - reaction-time game controller; optional best-time tracking under BEST_TIME_EN
module reaction_timer #(
    parameter int TICKS_PER_MS  = 100000,
    parameter int DELAY_UNIT_MS = 250,
    parameter int MAX_MS        = 9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [3:0]  r,
    output logic        led,
    output logic        busy,
    output logic [13:0] reaction_ms,
    output logic        valid,
    output logic        cheat,
    output logic [13:0] best_ms
);

    localparam int            PW         = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_MS - 1);
    localparam logic [11:0]   UNIT       = 12'(DELAY_UNIT_MS);
    localparam logic [13:0]   MAX_V      = 14'(MAX_MS);

    typedef enum logic [2:0] {IDLE, WAIT, LIT, DONE, FAULT} state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [11:0]   delay_ms;
    logic [13:0]   ms_cnt;
    logic          tick;
    logic [3:0]    r_eff;
    logic [11:0]   delay_load;

    // Millisecond tick and foreperiod length; r values 0 and 1 behave as 2
    always_comb begin
        tick       = (presc == PRESC_LAST);
        r_eff      = (r < 4'd2) ? 4'd2 : r;
        delay_load = {8'd0, r_eff} * UNIT;
    end

    // Round sequencing, prescaler and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            presc       <= '0;
            delay_ms    <= '0;
            ms_cnt      <= '0;
            led         <= 1'b0;
            busy        <= 1'b0;
            reaction_ms <= '0;
            valid       <= 1'b0;
            cheat       <= 1'b0;
        end else begin
            valid <= 1'b0;
            presc <= tick ? '0 : presc + 1'b1;
            case (state)
                WAIT: begin
                    if (stop) begin
                        cheat <= 1'b1;
                        busy  <= 1'b0;
                        state <= FAULT;
                    end else if (tick) begin
                        delay_ms <= delay_ms - 12'd1;
                        if (delay_ms == 12'd1) begin
                            state  <= LIT;
                            led    <= 1'b1;
                            presc  <= '0;
                            ms_cnt <= '0;
                        end
                    end
                end
                LIT: begin
                    if (stop || ms_cnt == MAX_V) begin
                        reaction_ms <= stop ? ms_cnt : MAX_V;
                        valid       <= 1'b1;
                        led         <= 1'b0;
                        busy        <= 1'b0;
                        state       <= DONE;
                    end else if (tick) begin
                        ms_cnt <= ms_cnt + 14'd1;
                    end
                end
                default: begin
                    if (start) begin
                        delay_ms <= delay_load;
                        presc    <= '0;
                        cheat    <= 1'b0;
                        busy     <= 1'b1;
                        state    <= WAIT;
                    end
                end
            endcase
        end
    end

`ifdef BEST_TIME_EN
    logic [13:0] best_r;

    // Keep the fastest player-stopped time; timeouts can never be smaller than the current best
    always_ff @(posedge clk) begin
        if (reset) begin
            best_r <= MAX_V;
        end else if (state == LIT && stop && ms_cnt < best_r) begin
            best_r <= ms_cnt;
        end
    end

    assign best_ms = best_r;
`else
    assign best_ms = MAX_V;
`endif

endmodule

// File: tb/tb_reaction_timer.sv
// tb/tb_reaction_timer.sv - randomized and directed bench for reaction_timer against a cycle-count model
module tb_reaction_timer;

    localparam int TPM  = 4;
    localparam int UNIT = 2;
    localparam int MAXV = 9999;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop  = 1'b0;
    logic [3:0]  r     = 4'd0;
    logic        led;
    logic        busy;
    logic [13:0] reaction_ms;
    logic        valid;
    logic        cheat;
    logic [13:0] best_ms;

    int vectors     = 0;
    int miscompares = 0;
    int d;
    int n;

`ifdef BEST_TIME_EN
    localparam bit BEST_EN = 1'b1;
`else
    localparam bit BEST_EN = 1'b0;
`endif

    reaction_timer #(
        .TICKS_PER_MS (TPM),
        .DELAY_UNIT_MS(UNIT),
        .MAX_MS       (MAXV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .r          (r),
        .led        (led),
        .busy       (busy),
        .reaction_ms(reaction_ms),
        .valid      (valid),
        .cheat      (cheat),
        .best_ms    (best_ms)
    );

    always #5 clk = ~clk;

    // Model: a round is a countdown of whole clock cycles, then a cycle count k in the lit phase
    typedef enum {M_IDLE, M_WAIT, M_LIT, M_DONE, M_FAULT} mph_t;
    mph_t m_ph        = M_IDLE;
    int   m_wait_left = 0;
    int   m_k         = 0;
    int   m_reaction  = 0;
    int   m_best      = MAXV;
    bit   m_valid     = 1'b0;
    bit   m_cheat     = 1'b0;

    task automatic model_step();
        if (reset) begin
            m_ph       = M_IDLE;
            m_reaction = 0;
            m_valid    = 1'b0;
            m_cheat    = 1'b0;
            m_best     = MAXV;
        end else begin
            m_valid = 1'b0;
            case (m_ph)
                M_WAIT: begin
                    if (stop) begin
                        m_ph    = M_FAULT;
                        m_cheat = 1'b1;
                    end else begin
                        m_wait_left--;
                        if (m_wait_left == 0) begin
                            m_ph = M_LIT;
                            m_k  = 0;
                        end
                    end
                end
                M_LIT: begin
                    if (stop || (m_k / TPM) >= MAXV) begin
                        m_reaction = stop ? (m_k / TPM) : MAXV;
                        m_valid    = 1'b1;
                        m_ph       = M_DONE;
                        if (BEST_EN && stop && m_reaction < m_best) m_best = m_reaction;
                    end else begin
                        m_k++;
                    end
                end
                default: begin
                    if (start) begin
                        m_ph        = M_WAIT;
                        m_cheat     = 1'b0;
                        m_wait_left = ((int'(r) < 2) ? 2 : int'(r)) * UNIT * TPM;
                    end
                end
            endcase
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("led",         32'(led),         32'(m_ph == M_LIT));
        chk("busy",        32'(busy),        32'(m_ph == M_WAIT || m_ph == M_LIT));
        chk("reaction_ms", 32'(reaction_ms), m_reaction);
        chk("valid",       32'(valid),       32'(m_valid));
        chk("cheat",       32'(cheat),       32'(m_cheat));
        chk("best_ms",     32'(best_ms),     m_best);
    endtask

    task automatic step(input bit s_start, input bit s_stop, input bit s_reset);
        start = s_start;
        stop  = s_stop;
        reset = s_reset;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        start = 1'b0;
        stop  = 1'b0;
        reset = 1'b0;
    endtask

    task automatic wait_led(output int cycles);
        cycles = 0;
        while (led !== 1'b1 && cycles < 200) begin
            step(1'b0, 1'b0, 1'b0);
            cycles++;
        end
        if (led !== 1'b1) cycles = -1;
    endtask

    task automatic round(input logic [3:0] rv, input int k, output int dly);
        r = rv;
        step(1'b1, 1'b0, 1'b0);
        wait_led(dly);
        repeat (k) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("rst_led",         32'(led),         0);
        chk("rst_busy",        32'(busy),        0);
        chk("rst_reaction",    32'(reaction_ms), 0);
        chk("rst_valid",       32'(valid),       0);
        chk("rst_cheat",       32'(cheat),       0);
        chk("rst_best",        32'(best_ms),     9999);

        round(4'd2, 28, d);
        chk("seq_res7",  32'(reaction_ms), 7);
        chk("seq_best1", 32'(best_ms),     BEST_EN ? 7 : 9999);
        round(4'd2, 12, d);
        chk("seq_res3",  32'(reaction_ms), 3);
        chk("seq_best2", 32'(best_ms),     BEST_EN ? 3 : 9999);
        round(4'd2, 20, d);
        chk("seq_res5",  32'(reaction_ms), 5);
        chk("seq_best3", 32'(best_ms),     BEST_EN ? 3 : 9999);

        round(4'd3, 10, d);
        chk("r3_led_delay",  d,                24);
        chk("r3_reaction",   32'(reaction_ms), 2);
        chk("r3_valid",      32'(valid),       1);
        chk("r3_busy_fall",  32'(busy),        0);
        chk("r3_led_fall",   32'(led),         0);
        step(1'b0, 1'b0, 1'b0);
        chk("r3_valid_single", 32'(valid), 0);

        r = 4'd5;
        step(1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("cheat_set",  32'(cheat), 1);
        chk("cheat_busy", 32'(busy),  0);
        repeat (50) step(1'b0, 1'b0, 1'b0);
        chk("cheat_led_low", 32'(led),   0);
        chk("cheat_held",    32'(cheat), 1);
        round(4'd2, 8, d);
        chk("cheat_cleared", 32'(cheat), 0);
        chk("after_cheat_delay", d, 16);

        round(4'd0, 8, d);
        chk("r0_delay", d, 16);
        round(4'd1, 8, d);
        chk("r1_delay", d, 16);
        round(4'd15, 8, d);
        chk("r15_delay", d, 120);

        r = 4'd2;
        step(1'b1, 1'b0, 1'b0);
        wait_led(d);
        n = 0;
        while (valid !== 1'b1 && n < 45000) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end
        chk("timeout_cycles",   n,                MAXV * TPM + 1);
        chk("timeout_reaction", 32'(reaction_ms), 9999);
        chk("timeout_best",     32'(best_ms),     BEST_EN ? 2 : 9999);

        r = 4'd2;
        step(1'b1, 1'b0, 1'b0);
        wait_led(d);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("midlit_rst_led",      32'(led),         0);
        chk("midlit_rst_busy",     32'(busy),        0);
        chk("midlit_rst_reaction", 32'(reaction_ms), 0);
        chk("midlit_rst_valid",    32'(valid),       0);

        r = 4'd4;
        step(1'b1, 1'b1, 1'b0);
        chk("startstop_busy",  32'(busy),  1);
        chk("startstop_cheat", 32'(cheat), 0);

        for (int i = 0; i < 6000; i++) begin
            r = 4'($urandom);
            step($urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 999) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
